// File: rtl/addsub_pkg.sv
// addsub_pkg: shared constants, FSM encoding and sizing helper for the serial adder/subtractor
package addsub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  // Minimum of 1 so a single-digit configuration still has a counter bit
  function automatic int clog2(input int v);
    int r;
    for (r = 1; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/addsub_digit.sv
// addsub_digit: combinational DIGIT-bit ripple adder built from full-adder cells
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  logic [DIGIT:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor with start/busy/done handshake
// and registered result, carry/borrow, signed-overflow and zero flags.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout_bout,
  output logic             overflow,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (DIGIT < 1 || WIDTH < DIGIT || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("addsub_serial: WIDTH must be a positive multiple of DIGIT");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d, carry_q, carry_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dc_msb;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_q[cnt_q*DIGIT +: DIGIT]),
    .b    (b_q[cnt_q*DIGIT +: DIGIT]),
    .cin  (carry_q),
    .sum  (dsum),
    .cout (dcout),
    .c_msb(dc_msb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (state_q == ST_RUN) begin
      acc_d[cnt_q*DIGIT +: DIGIT] = dsum;
      carry_d = dcout;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        s_d     = acc_d;
        cout_d  = dcout ^ mode_q;
        ovf_d   = dcout ^ dc_msb;
        zero_d  = (acc_d == '0);
        state_d = ST_DONE;
      end
    end else if (start) begin
      a_d     = a;
      b_d     = (mode == MODE_SUB) ? ~b : b;
      mode_d  = mode;
      carry_d = mode;
      cnt_d   = '0;
      state_d = ST_RUN;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign s         = s_q;
  assign cout_bout = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: scoreboard bench for addsub_serial at WIDTH=8, DIGIT=4
module tb_addsub_serial;
  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout_bout, overflow, zero;
  logic [7:0] s;
  logic [7:0] prev_s = '0;
  int         checks = 0;
  int         failures = 0;
  exp_t       q[$];

  addsub_serial #(.WIDTH(8), .DIGIT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .cout_bout(cout_bout),
    .overflow (overflow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic m, input logic [7:0] x, input logic [7:0] y);
    logic [8:0] f;
    exp_t e;
    f   = {1'b0, x} + {1'b0, m ? ~y : y} + 9'(m);
    e.s = f[7:0];
    e.c = f[8] ^ m;
    e.v = m ? (x[7] != y[7] && e.s[7] != x[7]) : (x[7] == y[7] && e.s[7] != x[7]);
    e.z = (e.s == 8'h00);
    return e;
  endfunction

  task automatic drive(input logic m, input logic [7:0] x, input logic [7:0] y, input bit push);
    start = 1'b1;
    mode  = m;
    a     = x;
    b     = y;
    if (push) q.push_back(model(m, x, y));
  endtask

  // Waits for done; with hold set, start stays high with scrambled operands while busy
  task automatic wait_done(input bit hold);
    int n = 0;
    int nb = 0;
    bit seen = 0;
    while (n < 10 && !seen) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
        check("busy_in_done", busy, 0);
      end else begin
        if (busy) nb++;
        start = hold;
        if (hold) begin
          a    = $urandom_range(0, 255);
          b    = $urandom_range(0, 255);
          mode = ~mode;
        end
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", n, 3);
    check("busy_cycles", nb, 2);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) prev_s = '0;
    else begin
      if (busy) check("s_hold", s, prev_s);
      if (done) begin
        if (q.size() == 0) check("spurious_done", 1, 0);
        else begin
          e = q.pop_front();
          check("s", s, e.s);
          check("cout_bout", cout_bout, e.c);
          check("overflow", overflow, e.v);
          check("zero", zero, e.z);
        end
        prev_s = s;
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout_bout, 0);
    check("rst_ovf", overflow, 0);
    check("rst_zero", zero, 1);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 8'h05, 8'h03, 1); wait_done(0);
    @(negedge clk);
    drive(1, 8'h03, 8'h05, 1); wait_done(0);
    drive(0, 8'h7F, 8'h01, 1); wait_done(0);
    drive(1, 8'h80, 8'h01, 1); wait_done(0);
    @(negedge clk);
    drive(0, 8'hFF, 8'h01, 1); wait_done(0);
    drive(1, 8'h5A, 8'h5A, 1); wait_done(0);
    @(negedge clk);
    drive(0, 8'h12, 8'h34, 1); wait_done(1);
    drive(1, 8'h40, 8'hC0, 1); wait_done(0);
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
      wait_done(i[0]);
      if (i[1]) @(negedge clk);
    end
    @(negedge clk);
    drive(0, 8'hAA, 8'h11, 0);
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_s", s, 0);
    check("mid_rst_cout", cout_bout, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_zero", zero, 1);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_idle", done | busy, 0);
    end
    drive(0, 8'h21, 8'h43, 1); wait_done(0);
    @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
